// File: rtl/vreg_row_scheduler_pkg.sv
// Shared constants and state encoding for the vertical-register row scheduler.
// Holds the kernel-size limit, the vertical-register return latency and the kernel clamp helper.
package vreg_row_scheduler_pkg;

    localparam int VR_KERNEL_SIZE = 3;
    localparam int VR_PIPE_DEPTH  = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FILL    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_SLIDE   = 3'd4,
        ST_FINISH  = 3'd5
    } state_e;

    // Kernel of 0 means 1; anything above the register depth is clamped to it.
    function automatic logic [7:0] clamp_kernel(input logic [7:0] k, input int unsigned kmax);
        logic [7:0] res;
        if (k == 8'd0) begin
            res = 8'd1;
        end else if (32'(k) > kmax) begin
            res = 8'(kmax);
        end else begin
            res = k;
        end
        return res;
    endfunction

endpackage

// File: rtl/vreg_row_scheduler_done_counter.sv
// Counts vr_shift_done returns and flags the pulse that brings the count up to the expected value.
// The count clears itself on that pulse so the next wait starts from zero.
module vreg_done_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    input  logic [CNT_W-1:0] expected,
    output logic             hit
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;

    assign count_inc = count + CNT_W'(inc);
    assign hit       = inc && (count_inc == expected);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear || hit) begin
            count <= '0;
        end else if (inc) begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/vreg_row_scheduler.sv
// Streams feature rows from the ping-pong line buffers into the vertical register and presents
// each completed KxK window to the select array, sliding one row per accepted window.
module vreg_row_scheduler
    import vreg_row_scheduler_pkg::*;
#(
    parameter int KERNEL_SIZE = VR_KERNEL_SIZE,
    parameter int ADDR_WIDTH  = 10,
    parameter int ROW_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            cfg_kernel_size,
    input  logic [ROW_WIDTH-1:0]  cfg_num_rows,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr_0,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr_1,
    output logic                  vr_enable,
    output logic                  vr_in_select,
    output logic [ADDR_WIDTH-1:0] vr_rd_addr,
    input  logic                  vr_shift_done,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    // Never more returns in flight than the larger of kernel depth and register latency.
    localparam int MAX_PEND = (KERNEL_SIZE > VR_PIPE_DEPTH) ? KERNEL_SIZE : VR_PIPE_DEPTH;
    localparam int CNT_W    = $clog2(MAX_PEND + 1);

    state_e                state;
    state_e                state_nxt;
    logic [ROW_WIDTH-1:0]  row_idx;
    logic [ROW_WIDTH-1:0]  row_idx_nxt;
    logic [CNT_W-1:0]      expected;
    logic [CNT_W-1:0]      expected_nxt;
    logic                  err_flag;
    logic                  err_flag_nxt;
    logic [ROW_WIDTH-1:0]  k_q;
    logic [ROW_WIDTH-1:0]  r_q;
    logic [ADDR_WIDTH-1:0] base0_q;
    logic [ADDR_WIDTH-1:0] base1_q;
    logic [ROW_WIDTH-1:0]  k_start;
    logic                  issue;
    logic [ROW_WIDTH-1:0]  issue_row;
    logic [ADDR_WIDTH-1:0] issue_base0;
    logic [ADDR_WIDTH-1:0] issue_base1;
    logic                  cnt_clear;
    logic                  cnt_inc;
    logic                  cnt_hit;

    function automatic logic [ADDR_WIDTH-1:0] row_addr(input logic [ROW_WIDTH-1:0]  row,
                                                       input logic [ADDR_WIDTH-1:0] b0,
                                                       input logic [ADDR_WIDTH-1:0] b1);
        logic [ROW_WIDTH-1:0] half;
        half = row >> 1;
        return (row[0] ? b1 : b0) + ADDR_WIDTH'(half);
    endfunction

    assign k_start = ROW_WIDTH'(clamp_kernel(cfg_kernel_size, KERNEL_SIZE));

    // The first row is issued in the same cycle start is taken, before the cfg registers load.
    assign issue_base0 = (state == ST_IDLE) ? cfg_base_addr_0 : base0_q;
    assign issue_base1 = (state == ST_IDLE) ? cfg_base_addr_1 : base1_q;

    assign cnt_inc = vr_shift_done && (state == ST_WAIT);

    vreg_done_counter #(
        .CNT_W (CNT_W)
    ) u_done_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .inc      (cnt_inc),
        .expected (expected),
        .hit      (cnt_hit)
    );

    always_comb begin
        state_nxt    = state;
        row_idx_nxt  = row_idx;
        expected_nxt = expected;
        err_flag_nxt = err_flag;
        issue        = 1'b0;
        issue_row    = row_idx;
        cnt_clear    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    cnt_clear   = 1'b1;
                    row_idx_nxt = '0;
                    if (cfg_num_rows < k_start) begin
                        err_flag_nxt = 1'b1;
                        state_nxt    = ST_FINISH;
                    end else begin
                        err_flag_nxt = 1'b0;
                        issue        = 1'b1;
                        issue_row    = '0;
                        row_idx_nxt  = ROW_WIDTH'(1);
                        state_nxt    = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                // row_idx counts rows already issued, so K issued means the fill is complete.
                if (row_idx == k_q) begin
                    expected_nxt = CNT_W'(k_q);
                    state_nxt    = ST_WAIT;
                end else begin
                    issue       = 1'b1;
                    row_idx_nxt = row_idx + ROW_WIDTH'(1);
                end
            end
            ST_WAIT: begin
                if (cnt_hit) begin
                    state_nxt = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (win_ready) begin
                    if (row_idx == r_q) begin
                        state_nxt = ST_FINISH;
                    end else begin
                        issue       = 1'b1;
                        row_idx_nxt = row_idx + ROW_WIDTH'(1);
                        state_nxt   = ST_SLIDE;
                    end
                end
            end
            ST_SLIDE: begin
                expected_nxt = CNT_W'(1);
                state_nxt    = ST_WAIT;
            end
            ST_FINISH: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            row_idx      <= '0;
            expected     <= '0;
            err_flag     <= 1'b0;
            vr_enable    <= 1'b0;
            vr_in_select <= 1'b0;
            vr_rd_addr   <= '0;
            win_valid    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state     <= state_nxt;
            row_idx   <= row_idx_nxt;
            expected  <= expected_nxt;
            err_flag  <= err_flag_nxt;
            vr_enable <= issue;
            if (issue) begin
                vr_in_select <= issue_row[0];
                vr_rd_addr   <= row_addr(issue_row, issue_base0, issue_base1);
            end
            win_valid <= (state_nxt == ST_PRESENT);
            busy      <= (state_nxt != ST_IDLE);
            done      <= (state == ST_FINISH);
            err       <= (state == ST_FINISH) && err_flag;
        end
    end

    // Run configuration is held only while a run is in flight; it needs no reset.
    always_ff @(posedge clk) begin
        if ((state == ST_IDLE) && start) begin
            k_q     <= k_start;
            r_q     <= cfg_num_rows;
            base0_q <= cfg_base_addr_0;
            base1_q <= cfg_base_addr_1;
        end
    end

endmodule

// File: tb/tb_vreg_row_scheduler.sv
// Bench for vreg_row_scheduler: directed and randomized runs against a row/window reference model,
// with a 3-cycle vertical-register responder generating vr_shift_done.
`timescale 1ns/1ps
module tb_vreg_row_scheduler;

    localparam int AW   = 10;
    localparam int RW   = 8;
    localparam int KMAX = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    cfg_kernel_size = '0;
    logic [RW-1:0] cfg_num_rows = '0;
    logic [AW-1:0] cfg_base_addr_0 = '0;
    logic [AW-1:0] cfg_base_addr_1 = '0;
    logic          vr_enable;
    logic          vr_in_select;
    logic [AW-1:0] vr_rd_addr;
    logic          vr_shift_done = 1'b0;
    logic          win_valid;
    logic          win_ready = 1'b0;
    logic          busy;
    logic          done;
    logic          err;

    vreg_row_scheduler #(
        .KERNEL_SIZE (KMAX),
        .ADDR_WIDTH  (AW),
        .ROW_WIDTH   (RW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .cfg_kernel_size (cfg_kernel_size),
        .cfg_num_rows    (cfg_num_rows),
        .cfg_base_addr_0 (cfg_base_addr_0),
        .cfg_base_addr_1 (cfg_base_addr_1),
        .vr_enable       (vr_enable),
        .vr_in_select    (vr_in_select),
        .vr_rd_addr      (vr_rd_addr),
        .vr_shift_done   (vr_shift_done),
        .win_valid       (win_valid),
        .win_ready       (win_ready),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;
    int s_cyc  = 0;
    int mode   = 0;
    int mid_start_off = 0;
    bit stray_en   = 1'b0;
    bit stray_used = 1'b0;
    logic [2:0] pipe = '0;

    int en_sel[$];
    int en_addr[$];
    int en_cyc[$];
    int acc_cyc[$];
    int wv_rise[$];
    int done_n, done_cyc, err_n, err_alone, overlap, drop, wait_cnt;
    logic prev_wv, prev_acc, busy_at1;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    endtask

    task automatic clear_logs();
        en_sel.delete(); en_addr.delete(); en_cyc.delete(); acc_cyc.delete(); wv_rise.delete();
        done_n = 0; done_cyc = -1; err_n = 0; err_alone = 0; overlap = 0; drop = 0;
        wait_cnt = 0; prev_wv = 1'b0; prev_acc = 1'b0; busy_at1 = 1'b0;
        stray_used = 1'b0;
    endtask

    // One clock: observe outputs mid-cycle, then drive inputs that the next rising edge samples.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (vr_enable) begin
            en_sel.push_back(int'(vr_in_select));
            en_addr.push_back(int'(vr_rd_addr));
            en_cyc.push_back(cyc);
        end
        if (vr_enable && win_valid) overlap++;
        if (prev_wv && !prev_acc && !win_valid) drop++;
        if (win_valid && !prev_wv) wv_rise.push_back(cyc);
        if (done) begin done_n++; done_cyc = cyc; end
        if (err) err_n++;
        if (err && !done) err_alone++;
        if (cyc == s_cyc + 1) busy_at1 = busy;
        start = (mid_start_off > 0) && (cyc == s_cyc + mid_start_off);
        vr_shift_done = pipe[2];
        if (stray_en && !stray_used && win_valid) begin
            vr_shift_done = 1'b1;
            stray_used = 1'b1;
        end
        pipe = {pipe[1:0], vr_enable};
        case (mode)
            0:       win_ready = 1'b1;
            1:       win_ready = win_valid && (wait_cnt >= 10);
            default: win_ready = 1'($urandom_range(0, 1));
        endcase
        if (win_valid) wait_cnt++;
        if (win_valid && win_ready) begin
            acc_cyc.push_back(cyc);
            wait_cnt = 0;
        end
        prev_wv  = win_valid;
        prev_acc = win_valid && win_ready;
    endtask

    task automatic run(input string tag, input int k, input int r, input int b0, input int b1,
                       input int md, input bit timing, input int mstart, input bit stray);
        int kc, nwin, nen, guard, exp_addr;
        bit experr;
        kc     = (k == 0) ? 1 : ((k > KMAX) ? KMAX : k);
        experr = (r < kc);
        nen    = experr ? 0 : r;
        nwin   = experr ? 0 : (r - kc + 1);
        clear_logs();
        mode = md; mid_start_off = mstart; stray_en = stray;
        cfg_kernel_size = 8'(k);
        cfg_num_rows    = RW'(r);
        cfg_base_addr_0 = AW'(b0);
        cfg_base_addr_1 = AW'(b1);
        s_cyc = cyc;
        start = 1'b1;
        guard = 0;
        while (done_n == 0 && guard < 3000) begin
            tick();
            guard++;
        end
        check({tag, ".timeout"}, int'(guard < 3000), 1);
        tick();
        tick();
        check({tag, ".n_enable"}, en_sel.size(), nen);
        for (int i = 0; i < nen && i < en_sel.size(); i++) begin
            exp_addr = (((i % 2) == 1 ? b1 : b0) + i / 2) % (1 << AW);
            check($sformatf("%s.row%0d", tag, i), en_sel[i] * 4096 + en_addr[i], (i % 2) * 4096 + exp_addr);
        end
        check({tag, ".windows"}, acc_cyc.size(), nwin);
        check({tag, ".done_cycles"}, done_n, 1);
        check({tag, ".err_cycles"}, err_n, int'(experr));
        check({tag, ".err_without_done"}, err_alone, 0);
        check({tag, ".enable_with_valid"}, overlap, 0);
        check({tag, ".valid_dropped"}, drop, 0);
        check({tag, ".busy_after_start"}, int'(busy_at1), 1);
        check({tag, ".busy_idle"}, int'(busy), 0);
        if (experr) check({tag, ".done_latency"}, done_cyc - s_cyc, 2);
        if (stray) check({tag, ".stray_sent"}, int'(stray_used), 1);
        if (timing) begin
            check({tag, ".timing_sizes"}, int'(en_cyc.size() >= 4 && wv_rise.size() >= 2 && acc_cyc.size() >= 1), 1);
            if (en_cyc.size() >= 4 && wv_rise.size() >= 2 && acc_cyc.size() >= 1) begin
                check({tag, ".first_enable"}, en_cyc[0] - s_cyc, 1);
                check({tag, ".third_enable"}, en_cyc[2] - s_cyc, 3);
                check({tag, ".first_valid"}, wv_rise[0] - s_cyc, 7);
                check({tag, ".slide_enable"}, en_cyc[3] - acc_cyc[0], 1);
                check({tag, ".slide_valid"}, wv_rise[1] - acc_cyc[0], 5);
            end
        end
        mid_start_off = 0;
        stray_en = 1'b0;
        repeat (3) tick();
    endtask

    task automatic check_outputs_reset(input string tag);
        check({tag, ".vr_enable"}, int'(vr_enable), 0);
        check({tag, ".vr_in_select"}, int'(vr_in_select), 0);
        check({tag, ".vr_rd_addr"}, int'(vr_rd_addr), 0);
        check({tag, ".win_valid"}, int'(win_valid), 0);
        check({tag, ".busy"}, int'(busy), 0);
        check({tag, ".done"}, int'(done), 0);
        check({tag, ".err"}, int'(err), 0);
    endtask

    initial begin
        int guard;
        clear_logs();
        repeat (3) tick();
        check_outputs_reset("reset");
        rst = 1'b1;
        repeat (3) tick();

        run("basic", 3, 5, 'h10, 'h40, 0, 1'b1, 0, 1'b0);
        run("backpressure", 3, 5, 'h10, 'h40, 1, 1'b0, 0, 1'b0);
        run("short", 3, 2, 'h10, 'h40, 0, 1'b0, 0, 1'b0);
        run("clamp_k0", 0, 2, 'h22, 'h33, 0, 1'b0, 0, 1'b0);
        run("clamp_k7", 7, 5, 'h10, 'h40, 0, 1'b1, 0, 1'b0);
        run("ignored", 3, 5, 'h10, 'h40, 1, 1'b0, 4, 1'b1);
        run("wrap", 2, 6, 'h3FE, 'h3FF, 0, 1'b0, 0, 1'b0);

        // Abort a run during its second wait for shift-done returns.
        clear_logs();
        mode = 0;
        cfg_kernel_size = 8'd3; cfg_num_rows = RW'(5);
        cfg_base_addr_0 = AW'('h10); cfg_base_addr_1 = AW'('h40);
        s_cyc = cyc;
        start = 1'b1;
        guard = 0;
        while (acc_cyc.size() == 0 && guard < 200) begin
            tick();
            guard++;
        end
        check("midreset.timeout", int'(guard < 200), 1);
        tick();
        tick();
        #2 rst = 1'b0;
        #1 check_outputs_reset("midreset");
        repeat (4) tick();
        rst = 1'b1;
        repeat (6) tick();
        check("midreset.no_done", done_n, 0);
        run("after_reset", 3, 5, 'h10, 'h40, 0, 1'b1, 0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            run($sformatf("rand%0d", i), int'($urandom_range(0, 7)), int'($urandom_range(0, 9)),
                int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                int'($urandom_range(0, 2)), 1'b0, 0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vreg_row_scheduler.md
# vreg_row_scheduler

Sequencing controller for the vertical feature-register buffer that feeds the select array. It streams feature rows from the two ping-pong line buffers into the vertical register and counts its shift-done returns. It presents each completed KxK window to the select array with a valid/ready handshake, then slides the window down one row until the configured row count is exhausted.

## Interface
- KERNEL_SIZE, 3, maximum kernel rows held by the vertical register
- ADDR_WIDTH, 10, line-buffer read address width
- ROW_WIDTH, 8, width of row counters and cfg_num_rows
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- cfg_kernel_size  in  8  kernel rows K; 0 is treated as 1, values above KERNEL_SIZE clamp to KERNEL_SIZE
- cfg_num_rows  in  ROW_WIDTH  total input rows R to stream
- cfg_base_addr_0  in  ADDR_WIDTH  first row address in bank 0 (even rows)
- cfg_base_addr_1  in  ADDR_WIDTH  first row address in bank 1 (odd rows)
- vr_enable  out  1  row-shift request to the vertical register
- vr_in_select  out  1  bank select for the row being shifted; equals row index bit 0
- vr_rd_addr  out  ADDR_WIDTH  bank read address; base of the selected bank + (row index >> 1)
- vr_shift_done  in  1  per-row completion pulse from the vertical register
- win_valid  out  1  window ready for the select array
- win_ready  in  1  select array accepts the window
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse, coincident with done, when R < K

## Operation
- The FSM has six states: IDLE, FILL, WAIT, PRESENT, SLIDE and FINISH.
- **IDLE:** start latches all cfg_* inputs and clears the row index and the pending-done counter.
  - If R < K, go to FINISH with err set.
  - Otherwise go to FILL.
- **FILL:** vr_enable is high for exactly K consecutive cycles.
  - Row index increments each cycle.
  - vr_in_select and vr_rd_addr are derived from the current row index.
  - After the K-th row, go to WAIT with expected = K.
- **WAIT:** each vr_shift_done pulse increments the pending-done counter. When the counter equals expected, clear it and go to PRESENT.
- **PRESENT:** win_valid is high and holds until sampled together with win_ready.
  - On acceptance, if row index == R, go to FINISH.
  - Otherwise go to SLIDE.
- **SLIDE:** one cycle with vr_enable high for the next row, then go to WAIT with expected = 1.
- **FINISH:** done (and err if flagged) pulses for one cycle, then go to IDLE.
- Windows presented per run = R − K + 1.
- vr_shift_done pulses outside WAIT are ignored.
- start outside IDLE is ignored.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- Row index comparison uses the full ROW_WIDTH.

## Timing
- All outputs are registered.
- Reset values: vr_enable, vr_in_select, win_valid, busy, done and err are 0; vr_rd_addr is 0; state is IDLE.
- The vertical register returns vr_shift_done 3 cycles after the cycle in which vr_enable is high.
- With start high at cycle 0 and K=3:
  - vr_enable is high in cycles 1–3.
  - vr_shift_done arrives in cycles 4–6.
  - win_valid rises in cycle 7.
- **Slide latency:** acceptance at cycle t gives vr_enable at t+1, vr_shift_done at t+4 and win_valid at t+5.
- win_valid never drops without acceptance.
- vr_enable is never high while win_valid is high.
- Reset assertion mid-run forces all outputs to their reset values immediately. No done pulse is produced for the aborted run.

## Structure
- Shared package (network parameters header): KERNEL_SIZE, the vertical-register pipeline depth (3), and the state encoding constants.
- Single module. The pending-done counter with its compare is a natural sub-module, `vreg_done_counter`.

## Test plan
- **Basic run:** K=3, R=5, base0=0x10, base1=0x40, win_ready tied 1.
  - Expect 5 enables with in_select 0,1,0,1,0.
  - Expect addresses 0x10, 0x40, 0x11, 0x41, 0x12.
  - Expect 3 win_valid handshakes, then done high for 1 cycle.
- **Backpressure:** win_ready held 0 for 10 cycles on each window.
  - win_valid stays high and no vr_enable is issued while waiting.
  - The sequence matches the basic run otherwise.
- **Short run:** R=2, K=3.
  - done and err pulse together 2 cycles after start.
  - No vr_enable is issued.
- **Clamping:** cfg_kernel_size=0 with R=2 gives 2 windows; cfg_kernel_size=7 behaves as K=3.
- **Ignored inputs:** start pulsed mid-run is ignored. A stray vr_shift_done in PRESENT leaves the enable and window counts unchanged.
- **Reset mid-run:** rst asserted during the second WAIT clears all outputs within the same cycle. A new start then reproduces the basic-run sequence exactly.
